// File: rtl/div_pkg.sv
// Shared definitions for the byte divider: default operand width and FSM states.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } divState_e;

endpackage

// File: rtl/trial_sub.sv
// Trial subtractor for one restoring-division step: difference plus a borrow
// that marks the trial result as negative (divisor did not fit).
module trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           neg
);

  logic [WIDTH+1:0] full;

  assign full = {1'b0, minuend} - {1'b0, subtrahend};
  assign diff = full[WIDTH:0];
  assign neg  = full[WIDTH+1];

endmodule

// File: rtl/byte_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for START; Q/R/DZ hold the last result
//   RUN   | WIDTH shift-subtract iterations, BUSY high
//   FIN   | one-cycle DONE pulse; a new START may be accepted here
module byte_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);

  localparam int CntW = $clog2(WIDTH) + 1;

  divState_e        state;
  divState_e        stateNext;
  logic             accept;
  logic             divZero;
  logic             lastIter;
  logic [CntW-1:0]  iterCnt;
  logic [WIDTH-1:0] divisor;

  // {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
  logic [2*WIDTH:0] work;
  logic [2*WIDTH:0] workSh;
  logic [2*WIDTH:0] workNext;
  logic [WIDTH:0]   trialDiff;
  logic             trialNeg;

  assign divZero  = (B == '0);
  assign lastIter = (iterCnt == CntW'(WIDTH - 1));
  assign workSh   = work << 1;

  trial_sub #(.WIDTH(WIDTH)) uTrialSub (
    .minuend   (workSh[2*WIDTH:WIDTH]),
    .subtrahend({1'b0, divisor}),
    .diff      (trialDiff),
    .neg       (trialNeg)
  );

  // One iteration: keep the trial remainder if it fits, shift in the quotient bit
  always_comb begin
    workNext = workSh;
    if (!trialNeg) begin
      workNext[2*WIDTH:WIDTH] = trialDiff;
    end
    workNext[0] = ~trialNeg;
  end

  // Next-state, handshake outputs and START acceptance
  always_comb begin
    stateNext = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: accept = START;
      RUN: begin
        BUSY = 1'b1;
        if (lastIter) stateNext = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        stateNext = IDLE;
        accept    = START;
      end
      default: stateNext = IDLE;
    endcase
    // A zero divisor needs no iterations and reports straight away
    if (accept) stateNext = divZero ? FIN : RUN;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Iteration counter, restarted on every accepted request
  always_ff @(posedge CLK) begin
    if (RST)                iterCnt <= '0;
    else if (accept)        iterCnt <= '0;
    else if (state == RUN)  iterCnt <= iterCnt + 1'b1;
  end

  // Datapath: operands are captured once so later A/B changes are ignored
  always_ff @(posedge CLK) begin
    if (RST) begin
      work    <= '0;
      divisor <= '0;
    end else if (accept) begin
      work    <= {{(WIDTH + 1){1'b0}}, A};
      divisor <= B;
    end else if (state == RUN) begin
      work    <= workNext;
    end
  end

  // Result registers: loaded on the final iteration or directly for divide-by-zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q  <= '0;
      R  <= '0;
      DZ <= 1'b0;
    end else if (accept) begin
      if (divZero) begin
        Q  <= '1;
        R  <= A;
        DZ <= 1'b1;
      end else begin
        DZ <= 1'b0;
      end
    end else if (state == RUN && lastIter) begin
      Q <= workNext[WIDTH-1:0];
      R <= workNext[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_byte_divider.sv
// Self-checking bench for byte_divider: vector table, random operands and
// hand-written reset / back-to-back sequences, with a result scoreboard.
module tb_byte_divider;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] A, B;
  logic       BUSY, DONE, DZ;
  logic [7:0] Q, R;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  int nCompared = 0;
  int nMismatch = 0;
  logic [7:0] lastQ, lastR;

  byte_divider #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .A    (A),
    .B    (B),
    .BUSY (BUSY),
    .DONE (DONE),
    .Q    (Q),
    .R    (R),
    .DZ   (DZ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatch++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding request
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("FAIL doneUnexpected: DONE high with no request outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resultQ", Q, e.q);
        check("resultR", R, e.r);
        check("resultDz", DZ, e.dz);
      end
    end
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    @(negedge CLK);
    START = 1'b1; A = a; B = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    sb.push_back(e);
    if (b == 0) begin
      @(negedge CLK);
      check("dzDoneNow", DONE, 1);
      check("dzBusy", BUSY, 0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        @(negedge CLK);
        check("runBusy", BUSY, 1);
        check("runDone", DONE, 0);
        if (i == 0) check("dzCleared", DZ, 0);
        if (i == 3) begin
          check("qHold", Q, lastQ);
          check("rHold", R, lastR);
        end
      end
      @(negedge CLK);
      check("finDone", DONE, 1);
      check("finBusy", BUSY, 0);
    end
    lastQ = e.q;
    lastR = e.r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = '{8'h2A,  8'd0,   8'hFF,  8'h2A,  1'b1};
    vecs[4] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
    vecs[8] = '{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1};
    vecs[9] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0};

    // Reset with a request already pending: accepted at the first edge out of reset
    RST = 1'b1; START = 1'b1; A = 8'd200; B = 8'd7;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rstBusy", BUSY, 0);
    check("rstDone", DONE, 0);
    check("rstQ", Q, 0);
    check("rstR", R, 0);
    check("rstDz", DZ, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = 8'd0; B = 8'd0;
    sb.push_back('{8'd28, 8'd4, 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("firstBusy", BUSY, 1);
    end
    @(negedge CLK);
    check("firstDone", DONE, 1);
    lastQ = 8'd28; lastR = 8'd4;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
      runOp(vecs[i].a, vecs[i].b, e);
    end

    // Random operands checked against the bench's arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 4 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      runOp(ra, rb, model(ra, rb));
    end

    // START held through RUN is ignored; still high in FIN it starts back-to-back
    @(negedge CLK);
    START = 1'b1; A = 8'd100; B = 8'd10;
    @(posedge CLK);
    #1;
    A = 8'd50; B = 8'd5;
    sb.push_back('{8'd10, 8'd0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("b2bFirstBusy", BUSY, 1);
    end
    @(negedge CLK);
    check("b2bFirstDone", DONE, 1);
    @(posedge CLK);
    #1;
    START = 1'b0;
    sb.push_back('{8'd10, 8'd0, 1'b0});
    @(negedge CLK);
    check("b2bNoBubble", BUSY, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      check("b2bSecondBusy", BUSY, 1);
    end
    @(negedge CLK);
    check("b2bSecondDone", DONE, 1);
    lastQ = 8'd10; lastR = 8'd0;

    // Reset on the 4th RUN cycle aborts without a DONE
    @(negedge CLK);
    START = 1'b1; A = 8'd200; B = 8'd7;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    check("abortPreBusy", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("abortBusy", BUSY, 0);
    check("abortDone", DONE, 0);
    check("abortQ", Q, 0);
    check("abortR", R, 0);
    check("abortDz", DZ, 0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("abortIdle", BUSY, 0);
    end

    check("sbEmpty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/byte_divider.md
BYTE_DIVIDER -- requirements
Module: byte_divider

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; the team uses only 8.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request to begin a division; sampled on CLK rising edge.
REQ-005 A  input  WIDTH  unsigned dividend; sampled only when START is accepted.
REQ-006 B  input  WIDTH  unsigned divisor; sampled only when START is accepted.
REQ-007 BUSY  output  1  high while iterations run.
REQ-008 DONE  output  1  one-cycle pulse; Q/R/DZ valid in that cycle.
REQ-009 Q  output  WIDTH  quotient; holds its value until the next accepted START.
REQ-010 R  output  WIDTH  remainder; holds its value until the next accepted START.
REQ-011 DZ  output  1  divide-by-zero flag; holds its value until the next accepted START.

Function
REQ-012 Algorithm: unsigned restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-013 States: IDLE, RUN, FIN.
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1, DONE=0.
  - FIN: BUSY=0, DONE=1.
REQ-014 START acceptance: START=1 at edge k is accepted only in IDLE or FIN; otherwise ignored (no queuing).
REQ-015 On acceptance:
  - latch A and B;
  - clear the partial remainder (WIDTH+1 bits);
  - clear DZ;
  - go to RUN; iteration counter = 0.
REQ-016 Per RUN cycle:
  - shift {rem, dividend} left one bit;
  - trial = rem - {0,B};
  - if trial is non-negative: rem = trial, quotient bit = 1;
  - else: rem is restored (unchanged), quotient bit = 0.
REQ-017 RUN lasts exactly WIDTH cycles (edges k+1..k+8). Edge k+8 enters FIN and loads Q and R. DONE is high in cycle k+8..k+9.
REQ-018 FIN lasts one cycle. Next state is IDLE, or RUN if START is accepted (back-to-back operation, no bubble).
REQ-019 Divide by zero: B=0 at acceptance skips RUN and enters FIN at edge k with Q=all-ones, R=A, DZ=1; DONE is high in cycle k..k+1.
REQ-020 Results satisfy A = Q*B + R with R < B for every B != 0; no overflow is possible.
REQ-021 Changes on A or B after acceptance do not affect the running division.
REQ-022 Iteration counter is log2(WIDTH)+1 bits and does not wrap during RUN.

Reset
REQ-023 RST=1 at an edge forces:
  - state IDLE;
  - BUSY=0, DONE=0, DZ=0;
  - Q=0, R=0;
  - counter and datapath registers to 0.
REQ-024 RST has priority over START. RST during RUN or FIN aborts the operation; no DONE is produced for it.
REQ-025 The first START is accepted at the first edge with RST=0.

Structure
REQ-026 Shared package div_pkg holds the state enum (IDLE/RUN/FIN) and the WIDTH default constant.
REQ-027 One sub-module, trial_sub: combinational (WIDTH+1)-bit subtractor returning difference and a borrow/negative flag. It is instantiated once.
REQ-028 All registers are in byte_divider; no latches; a single always block per register group.

Verification
REQ-029 A=200, B=7, START pulse -> BUSY for 8 cycles, then DONE for 1 cycle with Q=28, R=4, DZ=0.
REQ-030 A=255, B=1 -> Q=255, R=0.
REQ-031 A=5, B=9 -> Q=0, R=5.
REQ-032 A=0x2A, B=0 -> DONE in the cycle after acceptance with Q=0xFF, R=0x2A, DZ=1. A following A=9, B=3 clears DZ and gives Q=3, R=0.
REQ-033 START with A=100, B=10, then START held with A=50, B=5 during RUN -> second request ignored; Q=10, R=0. START held high through FIN starts 50/5 back-to-back, giving Q=10, R=0 after 8 more RUN cycles.
REQ-034 RST asserted on the 4th RUN cycle -> next cycle BUSY=0, DONE=0, Q=0, R=0, and no DONE pulse follows.
